// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit: exception codes, entry layout
// and the fetch-address legality test.
package fetch_queue_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CODE_W  = 5;
  localparam int ENTRY_W = PC_W + INSTR_W + CODE_W;

  localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CODE_W-1:0] EXC_NONE = 5'h1F;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CODE_W-1:0]  code;
  } fq_entry_t;

  // Misaligned or outside [base, limit] (unsigned) raises AdEL.
  function automatic logic fetch_fault(input logic [PC_W-1:0] pc,
                                       input logic [PC_W-1:0] base,
                                       input logic [PC_W-1:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and the decode stage.
interface fetch_queue_unit_if;
  logic        ExcFlush;
  logic        EretFlush;
  logic [31:0] EPC;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        BranchD;
  logic        ReadyD;
  logic [31:0] ImAddr;
  logic [31:0] ImData;
  logic [31:0] IRD;
  logic [31:0] PC4D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;
  logic        ValidD;

  modport master (
    input  ExcFlush, EretFlush, EPC, Redirect, RedirectPC, BranchD, ReadyD, ImData,
    output ImAddr, IRD, PC4D, ExcCode_D, BD_D, ValidD
  );

  modport slave (
    output ExcFlush, EretFlush, EPC, Redirect, RedirectPC, BranchD, ReadyD, ImData,
    input  ImAddr, IRD, PC4D, ExcCode_D, BD_D, ValidD
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Circular prefetch buffer with push/pop, full flush and flush-all-but-head.
module fetch_queue_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 69
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic                     i_flush_keep_head,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_flush && !i_flush_keep_head;
  assign w_pop  = i_pop  && !i_flush && !i_flush_keep_head;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_count  <= '0;
    end else if (i_flush_keep_head) begin
      if (r_count != '0) begin
        r_wr_ptr <= r_rd_ptr + 1'b1;
        r_count  <= CW'(1);
      end
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// IF stage: PC, pending-redirect and fault-halt control, prefetch queue, and the
// registered IF/ID output stage.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_4FFF,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] ADEL_INSTR = 32'h0000_0000
) (
  input logic               Clk,
  input logic               Reset,
  fetch_queue_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend;
  logic        r_halt;

  logic [31:0] r_ird_p1;
  logic [31:0] r_pc4d_p1;
  logic [4:0]  r_exc_p1;
  logic        r_bd_p1;
  logic        r_vld_p1;

  fq_entry_t     w_head;
  fq_entry_t     w_wentry;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic          w_adel;
  logic          w_deq;
  logic          w_can_push;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_keep;

  assign w_adel     = fetch_fault(r_pc, IM_BASE, IM_LIMIT);
  assign w_deq      = bus.ReadyD && !w_empty;
  assign w_can_push = !r_halt && (!w_full || w_deq);
  assign w_wentry   = '{pc:    r_pc,
                        instr: w_adel ? ADEL_INSTR : bus.ImData,
                        code:  w_adel ? EXC_ADEL   : EXC_NONE};

  // A redirect keeps only the delay slot at the head; when the head is leaving
  // this cycle nothing older survives, and an empty queue lets the old-PC fetch in.
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    w_keep  = 1'b0;
    if (bus.ExcFlush || bus.EretFlush) begin
      w_flush = 1'b1;
    end else if (bus.Redirect) begin
      if (!w_empty) begin
        if (w_deq) w_flush = 1'b1;
        else       w_keep  = (w_count > CW'(1));
      end else begin
        w_push = w_can_push;
      end
    end else begin
      w_push = w_can_push;
      w_pop  = w_deq;
    end
  end

  fetch_queue_unit_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .Clk               (Clk),
    .Reset             (Reset),
    .i_push            (w_push),
    .i_pop             (w_pop),
    .i_flush           (w_flush),
    .i_flush_keep_head (w_keep),
    .i_wdata           (w_wentry),
    .o_head            (w_head),
    .o_empty           (w_empty),
    .o_full            (w_full),
    .o_count           (w_count)
  );

  // ---- stage p1: PC control and IF/ID register ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc      <= PC_RESET;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_halt    <= 1'b0;
      r_ird_p1  <= '0;
      r_pc4d_p1 <= '0;
      r_exc_p1  <= EXC_NONE;
      r_bd_p1   <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (bus.ExcFlush) begin
      r_pc      <= EXC_VECTOR;
      r_pend    <= 1'b0;
      r_halt    <= 1'b0;
      r_ird_p1  <= '0;
      r_pc4d_p1 <= '0;
      r_exc_p1  <= EXC_NONE;
      r_bd_p1   <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (bus.EretFlush) begin
      r_pc   <= bus.EPC;
      r_pend <= 1'b0;
      r_halt <= 1'b0;
      if (bus.ReadyD) begin
        r_ird_p1  <= '0;
        r_pc4d_p1 <= bus.EPC + 32'd4;
        r_exc_p1  <= EXC_NONE;
        r_bd_p1   <= 1'b0;
        r_vld_p1  <= 1'b0;
      end
    end else begin
      if (bus.Redirect) begin
        // With nothing queued and no fetch this cycle, the delay slot is still owed.
        if (!w_empty || w_push) begin
          r_pc   <= bus.RedirectPC;
          r_pend <= 1'b0;
        end else begin
          r_pend    <= 1'b1;
          r_pend_pc <= bus.RedirectPC;
        end
        r_halt <= w_push && w_adel;
      end else if (w_push) begin
        r_pc   <= r_pend ? r_pend_pc : r_pc + 32'd4;
        r_pend <= 1'b0;
        if (w_adel) r_halt <= 1'b1;
      end

      if (bus.ReadyD) begin
        if (!w_empty) begin
          r_ird_p1  <= w_head.instr;
          r_pc4d_p1 <= w_head.pc + 32'd4;
          r_exc_p1  <= w_head.code;
          r_bd_p1   <= bus.BranchD;
          r_vld_p1  <= 1'b1;
        end else begin
          r_ird_p1 <= '0;
          r_exc_p1 <= EXC_NONE;
          r_bd_p1  <= 1'b0;
          r_vld_p1 <= 1'b0;
        end
      end
    end
  end

  assign bus.ImAddr    = r_pc;
  assign bus.IRD       = r_ird_p1;
  assign bus.PC4D      = r_pc4d_p1;
  assign bus.ExcCode_D = r_exc_p1;
  assign bus.BD_D      = r_bd_p1;
  assign bus.ValidD    = r_vld_p1;

endmodule
